// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM encoding and
// the access legality check used at request accept.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_RMW_READ = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  // Stores only have byte/half/word forms, so the unsigned load codes are illegal for them.
  function automatic logic access_err(input logic        we,
                                      input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input logic [31:0] last_addr);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_LB:   err = 1'b0;
      F3_LH:   err = addr[0];
      F3_LW:   err = (addr[1:0] != 2'b00);
      F3_LBU:  err = we;
      F3_LHU:  err = we | addr[0];
      default: err = 1'b1;
    endcase
    if (addr > last_addr) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load-data extension and sub-word store merge for the 4-byte RAM port.
// Byte at the access address sits in bits [7:0] of the RAM word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      F3_LH:   load_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      F3_LW:   load_data = mem_rdata;
      F3_LBU:  load_data = {24'd0, mem_rdata[7:0]};
      F3_LHU:  load_data = {16'd0, mem_rdata[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = wdata;
    case (funct3[1:0])
      2'b00:   store_word = {mem_rdata[31:8], wdata[7:0]};
      2'b01:   store_word = {mem_rdata[31:16], wdata[15:0]};
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side bridge from the execute stage to the 16 KB RAM data port.
// state    | meaning
// IDLE     | ready for a request; decode and legality check on accept
// LOAD     | RAM read, extended data captured into resp_rdata
// RMW_READ | RAM read for SB/SH, merged word captured into wdata_q
// WRITE    | RAM write of wdata_q (full SW data or merged word)
// RESP     | one-cycle resp_valid pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_SIZE - 4);

  logic [2:0]  state;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_err = access_err(req_we, req_funct3, req_addr, LAST_ADDR);

  lsu_align u_align (
    .funct3     (f3_q),
    .mem_rdata  (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
            if (req_err)                 state <= S_RESP;
            else if (!req_we)            state <= S_LOAD;
            else if (req_funct3 == F3_LW) state <= S_WRITE;
            else                         state <= S_RMW_READ;
          end
        end
        S_LOAD: begin
          rdata_q <= load_data;
          state   <= S_RESP;
        end
        S_RMW_READ: begin
          wdata_q <= store_word;
          state   <= S_WRITE;
        end
        S_WRITE: state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes come straight from state so an async reset kills them at once.
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_read   = (state == S_LOAD) || (state == S_RMW_READ);
  assign mem_write  = (state == S_WRITE);
  assign mem_addr   = (mem_read || mem_write) ? addr_q : '0;
  assign mem_wdata  = mem_write ? wdata_q : '0;

endmodule
